// File: rtl/mcu_spi_master.sv
// SPI master for the MCU link: 24-bit full-duplex frames from a TX FIFO, optional
// NOPE polling when the FIFO is empty, non-NOPE returned frames strobed out.
module mcu_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8,
    parameter int FIFO_AW = 4,
    parameter bit POLL    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic [23:0] tx_data,
    input  logic        tx_wr,
    output logic        tx_full,
    output logic        tx_overflow,
    output logic [23:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] SCK_HI = 3'd2;
    localparam logic [2:0] SCK_LO = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] GAP    = 3'd5;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0]      GAP_LAST = 16'(CS_GAP - 1);
    localparam logic [23:0]      NOPE     = 24'hFF0000;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [23:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [23:0]        next_frame;

    logic [2:0]  state;
    logic [7:0]  div_cnt;
    logic [15:0] gap_cnt;
    logic [4:0]  bit_cnt;
    logic        hold_phase;
    logic        div_done;
    logic [23:0] tx_sh;
    logic [23:0] rx_sh;

    assign fifo_empty = (count == '0);
    assign tx_full    = (count == FULL_CNT);
    assign push       = tx_wr && !tx_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign next_frame = fifo_empty ? NOPE : mem[rd_ptr];
    assign div_done   = (div_cnt == DIV_LAST);
    assign busy       = !spi_cs_n || (state == GAP);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (tx_wr && tx_full) tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            hold_phase <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            spi_sck    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty || POLL) begin
                        tx_sh      <= next_frame;
                        spi_mosi   <= next_frame[23];
                        spi_cs_n   <= 1'b0;
                        bit_cnt    <= 5'd23;
                        div_cnt    <= '0;
                        hold_phase <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP, SCK_LO: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        spi_sck <= 1'b1;
                        state   <= SCK_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SCK_HI: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        rx_sh   <= {rx_sh[22:0], spi_miso};
                        spi_sck <= 1'b0;
                        if (bit_cnt == 5'd0) begin
                            state <= HOLD;
                        end else begin
                            tx_sh    <= {tx_sh[22:0], 1'b0};
                            spi_mosi <= tx_sh[22];
                            bit_cnt  <= bit_cnt - 1'b1;
                            state    <= SCK_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                // HOLD spans the low half of SCK period 24 plus one CS hold half-period.
                HOLD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!hold_phase) begin
                            hold_phase <= 1'b1;
                        end else begin
                            spi_cs_n <= 1'b1;
                            if (rx_sh[23:16] != 8'hFF) begin
                                rx_data  <= rx_sh;
                                rx_valid <= 1'b1;
                            end
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_spi_master.sv
// Bench for mcu_spi_master: one POLL=0 and one POLL=1 instance, each with a
// behavioural SPI slave and a frame monitor.
module tb_mcu_spi_master;
    typedef struct {
        logic [23:0] tx;
        logic [23:0] rv;
        logic        v;
    } vec_t;

    logic clk;
    logic rst   [2];
    logic sck   [2];
    logic cs    [2];
    logic mosi  [2];
    logic miso  [2];
    logic wr    [2];
    logic full  [2];
    logic ovf   [2];
    logic rxv   [2];
    logic bsy   [2];
    logic [23:0] txd [2];
    logic [23:0] rxd [2];
    logic [23:0] ret [2];

    int total = 0;
    int bad = 0;

    // monitor / slave state
    int fn [2] = '{default: 0};
    int rn [2] = '{default: 0};
    int lowc [2] = '{default: 0};
    int rises [2] = '{default: 0};
    int hic [2] = '{default: 0};
    logic psck [2] = '{default: 1'b0};
    logic pcs [2] = '{default: 1'b1};
    logic [4:0] idx [2] = '{default: 5'd23};
    logic [23:0] msh [2] = '{default: 24'h0};
    logic [23:0] fw [2][64];
    int flow [2][64];
    int frise [2][64];
    int gapl [2][64];
    logic [23:0] rxw [2][64];
    logic rxr [2][64];

    mcu_spi_master #(.CLK_DIV(4), .CS_GAP(8), .FIFO_AW(4), .POLL(1'b0)) u0 (
        .clk(clk), .reset(rst[0]), .spi_sck(sck[0]), .spi_cs_n(cs[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .tx_data(txd[0]), .tx_wr(wr[0]), .tx_full(full[0]),
        .tx_overflow(ovf[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]), .busy(bsy[0])
    );

    mcu_spi_master #(.CLK_DIV(4), .CS_GAP(8), .FIFO_AW(4), .POLL(1'b1)) u1 (
        .clk(clk), .reset(rst[1]), .spi_sck(sck[1]), .spi_cs_n(cs[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .tx_data(txd[1]), .tx_wr(wr[1]), .tx_full(full[1]),
        .tx_overflow(ovf[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        miso[0] = 1'b0;
        miso[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!cs[k] && pcs[k]) begin
                    gapl[k][fn[k] & 63] = hic[k];
                    lowc[k] = 0;
                    rises[k] = 0;
                end
                if (!cs[k]) begin
                    lowc[k]++;
                    if (sck[k] && !psck[k]) begin
                        msh[k] = {msh[k][22:0], mosi[k]};
                        rises[k]++;
                    end
                end
                if (cs[k] && !pcs[k]) begin
                    fw[k][fn[k] & 63] = msh[k];
                    flow[k][fn[k] & 63] = lowc[k];
                    frise[k][fn[k] & 63] = rises[k];
                    fn[k]++;
                    hic[k] = 0;
                end
                if (cs[k]) hic[k]++;
                if (rxv[k]) begin
                    rxw[k][rn[k] & 63] = rxd[k];
                    rxr[k][rn[k] & 63] = cs[k] && !pcs[k];
                    rn[k]++;
                end
                if (cs[k]) idx[k] = 5'd23;
                else if (!sck[k] && psck[k] && idx[k] != 5'd0) idx[k] = idx[k] - 5'd1;
                miso[k] = ret[k][idx[k]];
                psck[k] = sck[k];
                pcs[k] = cs[k];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_fn(input int k, input int target, input int budget);
        int c;
        c = 0;
        while (fn[k] < target && c < budget) begin
            tick();
            c++;
        end
        chk("frame_wait", 32'(fn[k] >= target), 32'd1);
    endtask

    initial begin
        vec_t vec [5];
        int c, bf, br, rb;
        logic [23:0] last_rx;

        vec[0] = '{24'h0A5512, 24'h30BEEF, 1'b1};
        vec[1] = '{24'hFFFFFF, 24'h000001, 1'b1};
        vec[2] = '{24'h000000, 24'hFF1234, 1'b0};
        vec[3] = '{24'h800001, 24'hFEFFFF, 1'b1};
        vec[4] = '{24'hC3A55A, 24'h7F00FF, 1'b1};
        last_rx = 24'h0;

        for (int k = 0; k < 2; k++) begin
            wr[k] = 1'b0;
            txd[k] = 24'h0;
            rst[k] = 1'b0;
        end
        ret[0] = 24'h0;
        ret[1] = 24'hFF0000;
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_sck", 32'(sck[k]), 32'd0);
            chk("rst_cs_n", 32'(cs[k]), 32'd1);
            chk("rst_mosi", 32'(mosi[k]), 32'd0);
            chk("rst_full", 32'(full[k]), 32'd0);
            chk("rst_ovf", 32'(ovf[k]), 32'd0);
            chk("rst_rx_data", 32'(rxd[k]), 32'd0);
            chk("rst_rx_valid", 32'(rxv[k]), 32'd0);
            chk("rst_busy", 32'(bsy[k]), 32'd0);
        end
        rst[0] = 1'b0;
        repeat (3) tick();

        // single frames on the POLL=0 instance
        for (int i = 0; i < 5; i++) begin
            ret[0] = vec[i].rv;
            bf = fn[0];
            br = rn[0];
            tick();
            txd[0] = vec[i].tx;
            wr[0] = 1'b1;
            tick();
            wr[0] = 1'b0;
            chk("lat_cs_still_high", 32'(cs[0]), 32'd1);
            tick();
            chk("lat_cs_low", 32'(cs[0]), 32'd0);
            wait_fn(0, bf + 1, 400);
            chk("mosi_frame", 32'(fw[0][bf & 63]), 32'(vec[i].tx));
            chk("cs_low_cycles", 32'(flow[0][bf & 63]), 32'd200);
            chk("sck_rises", 32'(frise[0][bf & 63]), 32'd24);
            chk("rx_valid_count", 32'(rn[0] - br), 32'(vec[i].v));
            if (vec[i].v) begin
                chk("rx_word", 32'(rxw[0][br & 63]), 32'(vec[i].rv));
                chk("rx_at_cs_rise", 32'(rxr[0][br & 63]), 32'd1);
                last_rx = vec[i].rv;
            end
            repeat (12) tick();
            chk("rx_data_hold", 32'(rxd[0]), 32'(last_rx));
            chk("busy_idle", 32'(bsy[0]), 32'd0);
        end

        // 17 back-to-back pushes, then an 18th into a full FIFO
        ret[0] = 24'h0055AA;
        bf = fn[0];
        br = rn[0];
        for (int i = 0; i < 17; i++) begin
            tick();
            txd[0] = 24'h5A0000 | 24'(i);
            wr[0] = 1'b1;
        end
        tick();
        chk("fifo_full", 32'(full[0]), 32'd1);
        chk("no_ovf_yet", 32'(ovf[0]), 32'd0);
        txd[0] = 24'hDEAD00;
        tick();
        wr[0] = 1'b0;
        chk("ovf_set", 32'(ovf[0]), 32'd1);
        wait_fn(0, bf + 17, 17 * 260);
        for (int i = 0; i < 17; i++) begin
            chk("burst_order", 32'(fw[0][(bf + i) & 63]), 32'(24'h5A0000 | 24'(i)));
            if (i > 0) chk("burst_gap", 32'(gapl[0][(bf + i) & 63]), 32'd9);
        end
        repeat (300) tick();
        chk("burst_frame_count", 32'(fn[0] - bf), 32'd17);
        chk("burst_rx_count", 32'(rn[0] - br), 32'd17);
        chk("full_cleared", 32'(full[0]), 32'd0);
        chk("ovf_sticky", 32'(ovf[0]), 32'd1);

        // POLL=1 instance: NOPE polling
        rst[1] = 1'b0;
        wait_fn(1, 4, 1200);
        for (int i = 0; i < 4; i++) begin
            chk("nope_word", 32'(fw[1][i]), 32'hFF0000);
            chk("nope_low", 32'(flow[1][i]), 32'd200);
            if (i > 0) chk("nope_gap", 32'(gapl[1][i]), 32'd9);
        end
        chk("nope_no_rx", 32'(rn[1]), 32'd0);

        // push during GAP
        bf = fn[1];
        wait_fn(1, bf + 1, 400);
        tick();
        tick();
        txd[1] = 24'h0A5512;
        wr[1] = 1'b1;
        tick();
        wr[1] = 1'b0;
        wait_fn(1, bf + 2, 400);
        chk("gap_push_word", 32'(fw[1][(bf + 1) & 63]), 32'h0A5512);
        chk("gap_push_gap", 32'(gapl[1][(bf + 1) & 63]), 32'd9);
        chk("gap_push_no_rx", 32'(rn[1]), 32'd0);

        // reset at SCK rise 12 with frames queued
        c = 0;
        while (!cs[1] && c < 400) begin tick(); c++; end
        ret[1] = 24'h30BEEF;
        c = 0;
        while (cs[1] && c < 400) begin tick(); c++; end
        tick();
        txd[1] = 24'h111111;
        wr[1] = 1'b1;
        tick();
        txd[1] = 24'h222222;
        tick();
        wr[1] = 1'b0;
        c = 0;
        while (rises[1] < 12 && c < 400) begin tick(); c++; end
        chk("rise12_reached", 32'(rises[1]), 32'd12);
        chk("sck_high_before_rst", 32'(sck[1]), 32'd1);
        rb = rn[1];
        rst[1] = 1'b1;
        #1;
        chk("mid_rst_cs_n", 32'(cs[1]), 32'd1);
        chk("mid_rst_sck", 32'(sck[1]), 32'd0);
        chk("mid_rst_mosi", 32'(mosi[1]), 32'd0);
        chk("mid_rst_busy", 32'(bsy[1]), 32'd0);
        repeat (3) tick();
        chk("mid_rst_full", 32'(full[1]), 32'd0);
        chk("mid_rst_no_rx", 32'(rn[1] - rb), 32'd0);
        bf = fn[1];
        rst[1] = 1'b0;
        wait_fn(1, bf + 1, 600);
        chk("post_rst_flushed", 32'(fw[1][bf & 63]), 32'hFF0000);
        chk("post_rst_rises", 32'(frise[1][bf & 63]), 32'd24);
        chk("post_rst_low", 32'(flow[1][bf & 63]), 32'd200);
        chk("post_rst_rx_count", 32'(rn[1] - rb), 32'd1);
        chk("post_rst_rx_word", 32'(rxw[1][rb & 63]), 32'h30BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
